banked_register_file: RTL and testbench



---
 rtl/banked_register_file.sv | 150 +++++++++++++++
 tb/tb_banked_register_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_register_file.sv
// Multi-context register file: combinational reads, prioritized port writes
// and a sequential clear/copy engine that processes one register per cycle.
module banked_register_file #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CTX_W      = 1,
  parameter int unsigned LINK_REG   = 30,
  parameter int unsigned SAVEPC_REG = 26,
  parameter int unsigned END_REG    = 25
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Write,
  input  logic [ADDR_W-1:0] AddrWrite,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              jal,
  input  logic              change_so,
  input  logic              end_proc,
  input  logic [DATA_W-1:0] ProgramCounter,
  input  logic [CTX_W-1:0]  CtxWrite,
  input  logic [CTX_W-1:0]  CtxRead,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Addr2,
  input  logic [ADDR_W-1:0] Addr3,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] Data3,
  input  logic              OpStart,
  input  logic              OpCode,
  input  logic [CTX_W-1:0]  OpSrc,
  input  logic [CTX_W-1:0]  OpDst,
  output logic              OpBusy,
  output logic              OpDone
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam int unsigned NUM_CTX  = 2**CTX_W;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] LINK_ADDR   = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] SAVEPC_ADDR = ADDR_W'(SAVEPC_REG);
  localparam logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(END_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             code;
    logic [CTX_W-1:0] src;
    logic [CTX_W-1:0] dst;
  } op_t;

  logic [DATA_W-1:0] regs [NUM_CTX][NUM_REGS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  op_t               op_q, op_d;
  logic              bulk_we_c;
  logic [DATA_W-1:0] bulk_data_c;
  logic              port_ok_c;

  assign Data1 = regs[CtxRead][Addr1];
  assign Data2 = regs[CtxRead][Addr2];
  assign Data3 = regs[CtxRead][Addr3];

  // Port writes aimed at the context under bulk operation are dropped.
  assign port_ok_c = (state_q == IDLE) || (CtxWrite != op_q.dst);

  // Bulk engine next-state and per-cycle register update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    op_d        = op_q;
    bulk_we_c   = 1'b0;
    bulk_data_c = '0;
    case (state_q)
      IDLE: begin
        if (OpStart) begin
          state_d = RUN;
          idx_d   = '0;
          op_d    = '{code: OpCode, src: OpSrc, dst: OpDst};
        end
      end
      RUN: begin
        bulk_we_c   = 1'b1;
        bulk_data_c = op_q.code ? regs[op_q.src][idx_q] : '0;
        idx_d       = idx_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // OpDone trails the DONE state by one cycle so it lands after OpBusy drops.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      OpBusy  <= 1'b0;
      OpDone  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      OpBusy  <= (state_d != IDLE);
      OpDone  <= (state_q == DONE);
    end
  end

  // Later assignments win: Write > end_proc > change_so > jal.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          regs[CTX_W'(c)][ADDR_W'(r)] <= '0;
        end
      end
    end else begin
      if (port_ok_c) begin
        if (jal) begin
          regs[CtxWrite][LINK_ADDR] <= ProgramCounter + DATA_W'(1);
        end
        if (change_so) begin
          regs[CtxWrite][SAVEPC_ADDR] <= ProgramCounter;
        end
        if (end_proc) begin
          regs[CtxWrite][END_ADDR] <= DATA_W'(1);
        end
        if (Write) begin
          regs[CtxWrite][AddrWrite] <= DataIn;
        end
      end
      if (bulk_we_c) begin
        regs[op_q.dst][idx_q] <= bulk_data_c;
      end
    end
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Scoreboard bench for banked_register_file: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_banked_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Write;
  logic [4:0]  AddrWrite;
  logic [31:0] DataIn;
  logic        jal, change_so, end_proc;
  logic [31:0] ProgramCounter;
  logic        CtxWrite, CtxRead;
  logic [4:0]  Addr1, Addr2, Addr3;
  logic [31:0] Data1, Data2, Data3;
  logic        OpStart, OpCode, OpSrc, OpDst;
  logic        OpBusy, OpDone;

  banked_register_file dut (
    .Clock(Clock), .Reset(Reset), .Write(Write), .AddrWrite(AddrWrite),
    .DataIn(DataIn), .jal(jal), .change_so(change_so), .end_proc(end_proc),
    .ProgramCounter(ProgramCounter), .CtxWrite(CtxWrite), .CtxRead(CtxRead),
    .Addr1(Addr1), .Addr2(Addr2), .Addr3(Addr3),
    .Data1(Data1), .Data2(Data2), .Data3(Data3),
    .OpStart(OpStart), .OpCode(OpCode), .OpSrc(OpSrc), .OpDst(OpDst),
    .OpBusy(OpBusy), .OpDone(OpDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] e1, e2, e3;
    logic        ebusy, edone;
  } exp_t;

  exp_t q[$];
  logic chk_req = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: compares the oldest expectation whenever a check is presented.
  always @(negedge Clock) begin
    if (chk_req) begin
      tests_run++;
      if (q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard: check presented with empty expectation queue");
      end else begin
        exp_t e;
        logic ok;
        e  = q.pop_front();
        ok = (OpBusy == e.ebusy) && (OpDone == e.edone);
        if (e.chk_data) ok = ok && (Data1 == e.e1) && (Data2 == e.e2) && (Data3 == e.e3);
        if (!ok) begin
          tests_failed++;
          $display("FAIL %s: got d=%h/%h/%h busy=%b done=%b, want d=%h/%h/%h busy=%b done=%b (data %s)",
                   e.name, Data1, Data2, Data3, OpBusy, OpDone,
                   e.e1, e.e2, e.e3, e.ebusy, e.edone, e.chk_data ? "checked" : "ignored");
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic cd, input logic ctx,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                     input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                     input logic eb, input logic ed);
    exp_t e;
    CtxRead = ctx;
    Addr1 = a1; Addr2 = a2; Addr3 = a3;
    e.name = nm; e.chk_data = cd;
    e.e1 = e1; e.e2 = e2; e.e3 = e3;
    e.ebusy = eb; e.edone = ed;
    q.push_back(e);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic ctx, input logic [4:0] a, input logic [31:0] d);
    Write = 1'b1; CtxWrite = ctx; AddrWrite = a; DataIn = d;
    step();
    Write = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Write = 1'b0; AddrWrite = '0; DataIn = '0;
    jal = 1'b0; change_so = 1'b0; end_proc = 1'b0; ProgramCounter = '0;
    CtxWrite = 1'b0; CtxRead = 1'b0; Addr1 = '0; Addr2 = '0; Addr3 = '0;
    OpStart = 1'b0; OpCode = 1'b0; OpSrc = 1'b0; OpDst = 1'b0;
    step();
    Reset = 1'b0;

    // Reset state and basic read/write
    chk("rst ctx0", 1, 1'b0, 5'd0, 5'd25, 5'd31, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst ctx1", 1, 1'b1, 5'd0, 5'd25, 5'd31, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    Write = 1'b1; CtxWrite = 1'b1; AddrWrite = 5'd5; DataIn = 32'hDEADBEEF;
    chk("no bypass", 1, 1'b1, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    Write = 1'b0;
    chk("wr other ctx", 1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("wr ctx1", 1, 1'b1, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Special writes and priority (context 0)
    wr(1'b0, 5'd30, 32'h1234);
    jal = 1'b1; CtxWrite = 1'b0; ProgramCounter = 32'hFFFFFFFF;
    step();
    jal = 1'b0;
    chk("jal wrap", 1, 1'b0, 5'd30, 5'd30, 5'd30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    jal = 1'b1; ProgramCounter = 32'h41;
    step();
    jal = 1'b0;
    chk("jal pc+1", 1, 1'b0, 5'd30, 5'd30, 5'd30, 32'h42, 32'h42, 32'h42, 1'b0, 1'b0);
    change_so = 1'b1; ProgramCounter = 32'h300;
    step();
    change_so = 1'b0;
    chk("change_so", 1, 1'b0, 5'd26, 5'd26, 5'd26, 32'h300, 32'h300, 32'h300, 1'b0, 1'b0);
    change_so = 1'b1; ProgramCounter = 32'h100;
    wr(1'b0, 5'd26, 32'd7);
    change_so = 1'b0;
    chk("write>change_so", 1, 1'b0, 5'd26, 5'd26, 5'd26, 32'd7, 32'd7, 32'd7, 1'b0, 1'b0);
    end_proc = 1'b1;
    step();
    end_proc = 1'b0;
    chk("end_proc", 1, 1'b0, 5'd25, 5'd25, 5'd25, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    wr(1'b0, 5'd25, 32'd0);
    jal = 1'b1; change_so = 1'b1; end_proc = 1'b1; ProgramCounter = 32'h10;
    step();
    jal = 1'b0; change_so = 1'b0; end_proc = 1'b0;
    chk("all specials", 1, 1'b0, 5'd25, 5'd26, 5'd30, 32'd1, 32'h10, 32'h11, 1'b0, 1'b0);
    end_proc = 1'b1;
    wr(1'b0, 5'd25, 32'd9);
    end_proc = 1'b0;
    chk("write>end_proc", 1, 1'b0, 5'd25, 5'd26, 5'd30, 32'd9, 32'h10, 32'h11, 1'b0, 1'b0);

    // Clear context 1
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'(i + 1));
    chk("fill ctx1", 1, 1'b1, 5'd0, 5'd5, 5'd31, 32'd1, 32'd6, 32'd32, 1'b0, 1'b0);
    OpStart = 1'b1; OpCode = 1'b0; OpSrc = 1'b0; OpDst = 1'b1;
    step();
    OpStart = 1'b0;
    for (int c = 1; c <= 35; c++)
      chk($sformatf("clear c%0d", c), (c == 5), 1'b1, 5'd3, 5'd4, 5'd31,
          32'd0, 32'd5, 32'd32, (c <= 33), (c == 34));
    chk("clear ctx1 end", 1, 1'b1, 5'd0, 5'd17, 5'd31, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("clear ctx0 kept", 1, 1'b0, 5'd25, 5'd26, 5'd30, 32'd9, 32'h10, 32'h11, 1'b0, 1'b0);

    // Copy 0 -> 1 with interfering writes and a rejected OpStart
    for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 32'h0A0 + 32'(i));
    OpStart = 1'b1; OpCode = 1'b1; OpSrc = 1'b0; OpDst = 1'b1;
    step();
    OpStart = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin Write = 1'b1; CtxWrite = 1'b1; AddrWrite = 5'd3; DataIn = 32'hBAD; end
      if (c == 12) begin Write = 1'b1; CtxWrite = 1'b0; AddrWrite = 5'd31; DataIn = 32'h55; end
      if (c == 20 || c == 33) begin OpStart = 1'b1; OpCode = 1'b0; OpSrc = 1'b0; OpDst = 1'b0; end
      chk($sformatf("copy c%0d", c), 0, 1'b0, 5'd0, 5'd0, 5'd0,
          32'h0, 32'h0, 32'h0, (c <= 33), (c == 34));
      Write = 1'b0; OpStart = 1'b0;
    end
    chk("copy ctx1 a", 1, 1'b1, 5'd0, 5'd3, 5'd31, 32'hA0, 32'hA3, 32'h55, 1'b0, 1'b0);
    chk("copy ctx1 b", 1, 1'b1, 5'd10, 5'd25, 5'd30, 32'hAA, 32'hB9, 32'hBE, 1'b0, 1'b0);
    chk("copy ctx0", 1, 1'b0, 5'd0, 5'd3, 5'd31, 32'hA0, 32'hA3, 32'h55, 1'b0, 1'b0);

    // Reset during RUN at index 10
    OpStart = 1'b1; OpCode = 1'b0; OpSrc = 1'b0; OpDst = 1'b0;
    step();
    OpStart = 1'b0;
    for (int c = 1; c <= 10; c++)
      chk($sformatf("abort c%0d", c), 0, 1'b0, 5'd0, 5'd0, 5'd0,
          32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    Reset = 1'b1;
    chk("abort c11", 0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    Reset = 1'b0;
    OpStart = 1'b1; OpCode = 1'b1; OpSrc = 1'b0; OpDst = 1'b1;
    chk("post rst ctx0", 1, 1'b0, 5'd0, 5'd11, 5'd31, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    OpStart = 1'b0;
    chk("post rst ctx1", 1, 1'b1, 5'd0, 5'd10, 5'd31, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int c = 2; c <= 35; c++)
      chk($sformatf("restart c%0d", c), 0, 1'b0, 5'd0, 5'd0, 5'd0,
          32'h0, 32'h0, 32'h0, (c <= 33), (c == 34));

    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
